// File: rtl/data_bus_arbiter_if.sv
// Request/response bundle for one requester of the shared data-memory port.
// The requester drives the request fields. The arbiter returns the grant, the
// read-valid strobe and the read data.
interface data_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-requester arbiter for the core data-memory port.
// Master 0 is the LSU and master 1 is an auxiliary agent.
// Grants are combinational, so a request can be accepted every cycle.
// Arbitration is round-robin or fixed priority. An optional bounded lock lets
// one master keep the port for an atomic sequence. Each 1-cycle-latency read
// response is steered back to the master that issued the read.
module data_bus_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    data_bus_arbiter_if.slave  m0,
    data_bus_arbiter_if.slave  m1,
    input  logic [31:0]        data_rdata_i,
    output logic               data_req_o,
    output logic               data_we_o,
    output logic [3:0]         data_be_o,
    output logic [31:0]        data_addr_o,
    output logic [31:0]        data_wdata_o
);

    localparam int unsigned       CNT_W   = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
    localparam bit                LOCK_EN = (MAX_LOCK > 0);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_LOCK);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e       state_q, state_d;
    logic              lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              rsp_pend_q, rsp_pend_d;
    logic              rsp_id_q, rsp_id_d;

    logic [1:0]        req;
    logic [1:0]        lock_req;
    logic [1:0]        gnt;
    logic              gnt_idx;
    logic              any_gnt;
    logic              tie_win;
    logic [CNT_W-1:0]  cnt_inc;

    assign req      = {m1.req, m0.req};
    assign lock_req = {m1.lock, m0.lock};
    assign tie_win  = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
    assign any_gnt  = |gnt;
    assign gnt_idx  = gnt[1];
    assign cnt_inc  = lock_cnt_q + CNT_W'(1);

    // Grant selection: lock owner only, else single requester, else tie-break.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
        gnt = 2'b00;
        if (!rst_i) begin
            if (state_q == LOCKED) begin
                gnt[lock_owner_q] = req[lock_owner_q];
            end else if (req == 2'b11) begin
                gnt[tie_win] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // Pass the granted master's fields to the RAM; all zero when idle.
    always_comb begin
        data_req_o   = any_gnt;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_addr_o  = 32'h0;
        data_wdata_o = 32'h0;
        if (gnt[0]) begin
            data_we_o    = m0.we;
            data_be_o    = m0.be;
            data_addr_o  = m0.addr;
            data_wdata_o = m0.wdata;
        end else if (gnt[1]) begin
            data_we_o    = m1.we;
            data_be_o    = m1.be;
            data_addr_o  = m1.addr;
            data_wdata_o = m1.wdata;
        end
    end

    // Lock FSM: enter on a locking grant; leave on lock drop or beat limit.
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        unique case (state_q)
            UNLOCKED: begin
                if (LOCK_EN && any_gnt && lock_req[gnt_idx]) begin
                    // A limit of one beat releases on the same grant that took the lock.
                    if (CNT_MAX != CNT_W'(1)) begin
                        state_d      = LOCKED;
                        lock_owner_d = gnt_idx;
                        lock_cnt_d   = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                // While locked, any grant belongs to the owner.
                if (any_gnt) begin
                    lock_cnt_d = cnt_inc;
                end
                if (!lock_req[lock_owner_q] || (any_gnt && (cnt_inc == CNT_MAX))) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = UNLOCKED;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Round-robin pointer and read-response tracking for the next cycle.
    always_comb begin
        last_gnt_d = any_gnt ? gnt_idx : last_gnt_q;
        rsp_pend_d = any_gnt & ~data_we_o;
        rsp_id_d   = any_gnt ? gnt_idx : rsp_id_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled on the clock edge, so it sits inside the edge-triggered branch.
        if (rst_i) begin
            state_q      <= UNLOCKED;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= '0;
            last_gnt_q   <= 1'b1;
            rsp_pend_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            last_gnt_q   <= last_gnt_d;
            rsp_pend_q   <= rsp_pend_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign m0.rvalid = rsp_pend_q & ~rsp_id_q & ~rst_i;
    assign m1.rvalid = rsp_pend_q &  rsp_id_q & ~rst_i;
    assign m0.rdata  = data_rdata_i;
    assign m1.rdata  = data_rdata_i;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter. It runs a round-robin instance and a
// fixed-priority instance side by side, both with MAX_LOCK=3. Each instance
// has its own RAM model. A transaction-level reference model runs alongside.
module tb_data_bus_arbiter;
    localparam int MAXL = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Stimulus per instance k (0 = round-robin, 1 = fixed priority) and master i
    logic        req_s   [2][2];
    logic        we_s    [2][2];
    logic        lock_s  [2][2];
    logic [3:0]  be_s    [2][2];
    logic [31:0] addr_s  [2][2];
    logic [31:0] wdata_s [2][2];

    data_bus_arbiter_if mif_rr0();
    data_bus_arbiter_if mif_rr1();
    data_bus_arbiter_if mif_fp0();
    data_bus_arbiter_if mif_fp1();

    assign mif_rr0.req = req_s[0][0];  assign mif_rr0.we = we_s[0][0];  assign mif_rr0.be = be_s[0][0];
    assign mif_rr0.addr = addr_s[0][0]; assign mif_rr0.wdata = wdata_s[0][0]; assign mif_rr0.lock = lock_s[0][0];
    assign mif_rr1.req = req_s[0][1];  assign mif_rr1.we = we_s[0][1];  assign mif_rr1.be = be_s[0][1];
    assign mif_rr1.addr = addr_s[0][1]; assign mif_rr1.wdata = wdata_s[0][1]; assign mif_rr1.lock = lock_s[0][1];
    assign mif_fp0.req = req_s[1][0];  assign mif_fp0.we = we_s[1][0];  assign mif_fp0.be = be_s[1][0];
    assign mif_fp0.addr = addr_s[1][0]; assign mif_fp0.wdata = wdata_s[1][0]; assign mif_fp0.lock = lock_s[1][0];
    assign mif_fp1.req = req_s[1][1];  assign mif_fp1.we = we_s[1][1];  assign mif_fp1.be = be_s[1][1];
    assign mif_fp1.addr = addr_s[1][1]; assign mif_fp1.wdata = wdata_s[1][1]; assign mif_fp1.lock = lock_s[1][1];

    logic        d_req   [2];
    logic        d_we    [2];
    logic [3:0]  d_be    [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [31:0] d_rdata [2];

    data_bus_arbiter #(.FIXED_PRIO(1'b0), .MAX_LOCK(MAXL)) dut_rr (
        .clk_i(clk), .rst_i(rst), .m0(mif_rr0), .m1(mif_rr1), .data_rdata_i(d_rdata[0]),
        .data_req_o(d_req[0]), .data_we_o(d_we[0]), .data_be_o(d_be[0]),
        .data_addr_o(d_addr[0]), .data_wdata_o(d_wdata[0])
    );

    data_bus_arbiter #(.FIXED_PRIO(1'b1), .MAX_LOCK(MAXL)) dut_fp (
        .clk_i(clk), .rst_i(rst), .m0(mif_fp0), .m1(mif_fp1), .data_rdata_i(d_rdata[1]),
        .data_req_o(d_req[1]), .data_we_o(d_we[1]), .data_be_o(d_be[1]),
        .data_addr_o(d_addr[1]), .data_wdata_o(d_wdata[1])
    );

    // Background contents of each RAM word, so unwritten reads return distinct data
    function automatic logic [31:0] init_word(input int idx);
        return 32'h5A00_0000 ^ (32'(idx) * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // RAMs (256 words each) store contents XOR the background pattern
    bit [31:0] ram  [2][256];
    bit [31:0] gold [2][256];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (d_req[k]) begin
                if (d_we[k])
                    ram[k][d_addr[k][9:2]] <= merge(ram[k][d_addr[k][9:2]] ^ init_word(int'(d_addr[k][9:2])),
                                                    d_wdata[k], d_be[k]) ^ init_word(int'(d_addr[k][9:2]));
                else
                    d_rdata[k] <= ram[k][d_addr[k][9:2]] ^ init_word(int'(d_addr[k][9:2]));
            end
        end
    end

    // Reference model state: last winner, lock owner (-1 = none), beats under lock, pending read
    int          last_w [2];
    int          owner  [2];
    int          beats  [2];
    bit          pend   [2];
    int          pend_id [2];
    logic [31:0] pend_data [2];

    logic [1:0]  exp_gnt [2], exp_rv [2];
    logic        exp_dreq [2], exp_we [2];
    logic [3:0]  exp_be [2];
    logic [31:0] exp_addr [2], exp_wdata [2], exp_rdata [2];

    logic [1:0]  obs_gnt [2], obs_rv [2];
    logic        obs_dreq [2], obs_we [2];
    logic [3:0]  obs_be [2];
    logic [31:0] obs_addr [2], obs_wdata [2];
    logic [31:0] obs_rdata [2][2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // One cycle of the arbiter, stated as transactions: who wins, what the RAM sees, what comes back
    task automatic model_step(input int k);
        int w;
        int idx;
        bit fp;
        fp = (k == 1);
        exp_rv[k] = 2'b00;
        if (pend[k]) exp_rv[k][pend_id[k]] = 1'b1;
        exp_rdata[k] = pend_data[k];
        exp_gnt[k] = 2'b00; exp_dreq[k] = 1'b0; exp_we[k] = 1'b0;
        exp_be[k] = 4'h0; exp_addr[k] = 32'h0; exp_wdata[k] = 32'h0;
        if (rst) begin
            exp_rv[k] = 2'b00;
            last_w[k] = 1; owner[k] = -1; beats[k] = 0; pend[k] = 1'b0;
            return;
        end
        w = -1;
        if (owner[k] >= 0) begin
            if (req_s[k][owner[k]]) w = owner[k];
        end else if (req_s[k][0] && req_s[k][1]) begin
            w = fp ? 0 : 1 - last_w[k];
        end else if (req_s[k][0]) begin
            w = 0;
        end else if (req_s[k][1]) begin
            w = 1;
        end
        pend[k] = 1'b0;
        if (w >= 0) begin
            exp_gnt[k][w] = 1'b1;
            exp_dreq[k]  = 1'b1;
            exp_we[k]    = we_s[k][w];
            exp_be[k]    = be_s[k][w];
            exp_addr[k]  = addr_s[k][w];
            exp_wdata[k] = wdata_s[k][w];
            idx = int'(addr_s[k][w][9:2]);
            if (we_s[k][w]) begin
                gold[k][idx] = merge(gold[k][idx] ^ init_word(idx), wdata_s[k][w], be_s[k][w]) ^ init_word(idx);
            end else begin
                pend[k] = 1'b1;
                pend_id[k] = w;
                pend_data[k] = gold[k][idx] ^ init_word(idx);
            end
            last_w[k] = w;
        end
        if (owner[k] < 0) begin
            if (MAXL > 0 && w >= 0 && lock_s[k][w]) begin
                beats[k] = 1;
                owner[k] = (beats[k] == MAXL) ? -1 : w;
                if (owner[k] < 0) beats[k] = 0;
            end
        end else begin
            if (w == owner[k]) beats[k]++;
            if (!lock_s[k][owner[k]] || beats[k] == MAXL) begin
                owner[k] = -1;
                beats[k] = 0;
            end
        end
    endtask

    // Sample both instances mid-cycle, advance the model, move to just after the next edge
    task automatic tick();
        @(negedge clk);
        obs_gnt[0] = {mif_rr1.gnt, mif_rr0.gnt};       obs_gnt[1] = {mif_fp1.gnt, mif_fp0.gnt};
        obs_rv[0]  = {mif_rr1.rvalid, mif_rr0.rvalid}; obs_rv[1]  = {mif_fp1.rvalid, mif_fp0.rvalid};
        obs_rdata[0][0] = mif_rr0.rdata; obs_rdata[0][1] = mif_rr1.rdata;
        obs_rdata[1][0] = mif_fp0.rdata; obs_rdata[1][1] = mif_fp1.rdata;
        for (int k = 0; k < 2; k++) begin
            obs_dreq[k] = d_req[k]; obs_we[k] = d_we[k]; obs_be[k] = d_be[k];
            obs_addr[k] = d_addr[k]; obs_wdata[k] = d_wdata[k];
        end
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input int i, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
        for (int k = 0; k < 2; k++) begin
            req_s[k][i] = req; we_s[k][i] = we; be_s[k][i] = be;
            addr_s[k][i] = addr; wdata_s[k][i] = wdata; lock_s[k][i] = lock;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
        rst = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++; if (obs_gnt[k] !== 2'b00) begin failures++; $display("FAIL reset_gnt dut%0d: got %b want 00", k, obs_gnt[k]); end
                checks++; if (obs_rv[k] !== 2'b00) begin failures++; $display("FAIL reset_rvalid dut%0d: got %b want 00", k, obs_rv[k]); end
                checks++; if (obs_dreq[k] !== 1'b0) begin failures++; $display("FAIL reset_data_req dut%0d: got %b want 0", k, obs_dreq[k]); end
            end
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_gnt[k] !== 2'b01) begin failures++; $display("FAIL first_gnt dut%0d: got %b want 01", k, obs_gnt[k]); end
            checks++; if (obs_addr[k] !== 32'h10) begin failures++; $display("FAIL first_addr dut%0d: got %h want 00000010", k, obs_addr[k]); end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        do_reset();
        drive(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0);
        for (int t = 0; t < 7; t++) begin
            if (t == 6) idle_all();
            tick();
            if (t < 6) begin
                want = (t % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (obs_gnt[0] !== want) begin failures++; $display("FAIL rr_gnt t%0d: got %b want %b", t, obs_gnt[0], want); end
            end
            if (t > 0) begin
                want = (t % 2 == 1) ? 2'b01 : 2'b10;
                checks++; if (obs_rv[0] !== want) begin failures++; $display("FAIL rr_rvalid t%0d: got %b want %b", t, obs_rv[0], want); end
                if (want == 2'b01) begin
                    checks++; if (obs_rdata[0][0] !== init_word(32'h40)) begin failures++; $display("FAIL rr_rdata_m0 t%0d: got %h want %h", t, obs_rdata[0][0], init_word(32'h40)); end
                end else begin
                    checks++; if (obs_rdata[0][1] !== init_word(32'h80)) begin failures++; $display("FAIL rr_rdata_m1 t%0d: got %h want %h", t, obs_rdata[0][1], init_word(32'h80)); end
                end
            end
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        drive(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++; if (obs_gnt[1] !== 2'b01) begin failures++; $display("FAIL fp_gnt t%0d: got %b want 01", t, obs_gnt[1]); end
        end
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checks++; if (obs_gnt[1] !== 2'b10) begin failures++; $display("FAIL fp_m1_after_drop: got %b want 10", obs_gnt[1]); end
    endtask

    task automatic test_write_read();
        do_reset();
        drive(1, 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_gnt[k] !== 2'b10) begin failures++; $display("FAIL wr_gnt dut%0d: got %b want 10", k, obs_gnt[k]); end
            checks++; if ({obs_we[k], obs_wdata[k]} !== {1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wr_fields dut%0d: got %b/%h want 1/deadbeef", k, obs_we[k], obs_wdata[k]); end
        end
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_gnt[k] !== 2'b01) begin failures++; $display("FAIL rd_gnt dut%0d: got %b want 01", k, obs_gnt[k]); end
            checks++; if (obs_rv[k] !== 2'b00) begin failures++; $display("FAIL wr_no_rvalid dut%0d: got %b want 00", k, obs_rv[k]); end
        end
        idle_all();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_rv[k] !== 2'b01) begin failures++; $display("FAIL rd_rvalid dut%0d: got %b want 01", k, obs_rv[k]); end
            checks++; if (obs_rdata[k][0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata dut%0d: got %h want deadbeef", k, obs_rdata[k][0]); end
        end
    endtask

    task automatic test_lock();
        logic [1:0] seq_rr [4];
        seq_rr = '{2'b01, 2'b01, 2'b01, 2'b10};
        // Forced release after MAX_LOCK beats
        do_reset();
        drive(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++; if (obs_gnt[0] !== seq_rr[t]) begin failures++; $display("FAIL lock_forced t%0d: got %b want %b", t, obs_gnt[0], seq_rr[t]); end
            checks++; if (obs_gnt[1] !== 2'b01) begin failures++; $display("FAIL lock_forced_fp t%0d: got %b want 01", t, obs_gnt[1]); end
        end
        // Owner drops lock after one beat
        do_reset();
        drive(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
        tick();
        checks++; if (obs_gnt[0] !== 2'b01) begin failures++; $display("FAIL lock_drop_b0: got %b want 01", obs_gnt[0]); end
        lock_s[0][0] = 1'b0; lock_s[1][0] = 1'b0;
        tick();
        checks++; if (obs_gnt[0] !== 2'b01) begin failures++; $display("FAIL lock_drop_b1: got %b want 01", obs_gnt[0]); end
        tick();
        checks++; if (obs_gnt[0] !== 2'b10) begin failures++; $display("FAIL lock_drop_m1: got %b want 10", obs_gnt[0]); end
        // Idle owner still keeps the other master out until lock drops
        do_reset();
        drive(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_gnt[k] !== 2'b00) begin failures++; $display("FAIL lock_idle_owner dut%0d: got %b want 00", k, obs_gnt[k]); end
        end
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_gnt[k] !== 2'b00) begin failures++; $display("FAIL lock_release_cycle dut%0d: got %b want 00", k, obs_gnt[k]); end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_gnt[k] !== 2'b10) begin failures++; $display("FAIL lock_after_release dut%0d: got %b want 10", k, obs_gnt[k]); end
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        drive(1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_gnt[k] !== 2'b10) begin failures++; $display("FAIL mid_read_gnt dut%0d: got %b want 10", k, obs_gnt[k]); end
        end
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_rv[k] !== 2'b00) begin failures++; $display("FAIL mid_read_rvalid_rst dut%0d: got %b want 00", k, obs_rv[k]); end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_rv[k] !== 2'b00) begin failures++; $display("FAIL mid_read_rvalid_after dut%0d: got %b want 00", k, obs_rv[k]); end
        end
        // Leave the pointer on m0 and the lock held by m0, then reset
        drive(0, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0, 1'b1);
        tick();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_gnt[k] !== 2'b01) begin failures++; $display("FAIL ptr_reset dut%0d: got %b want 01", k, obs_gnt[k]); end
        end
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_gnt[k] !== 2'b10) begin failures++; $display("FAIL lock_reset dut%0d: got %b want 10", k, obs_gnt[k]); end
        end
    endtask

    task automatic test_random();
        bit held;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 2; i++) begin
                    held = req_s[k][i] && !exp_gnt[k][i];
                    if (held) begin
                        if ($urandom_range(0, 9) == 0) req_s[k][i] = 1'b0;
                    end else begin
                        req_s[k][i]   = ($urandom_range(0, 3) != 0);
                        we_s[k][i]    = ($urandom_range(0, 2) == 0);
                        be_s[k][i]    = 4'($urandom_range(1, 15));
                        addr_s[k][i]  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                        wdata_s[k][i] = $urandom;
                        lock_s[k][i]  = ($urandom_range(0, 3) == 0);
                    end
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++; if (obs_gnt[k] !== exp_gnt[k]) begin failures++; $display("FAIL rnd_gnt dut%0d cyc%0d: got %b want %b", k, cyc, obs_gnt[k], exp_gnt[k]); end
                checks++; if (obs_dreq[k] !== exp_dreq[k]) begin failures++; $display("FAIL rnd_data_req dut%0d cyc%0d: got %b want %b", k, cyc, obs_dreq[k], exp_dreq[k]); end
                checks++; if ({obs_we[k], obs_be[k], obs_addr[k], obs_wdata[k]} !== {exp_we[k], exp_be[k], exp_addr[k], exp_wdata[k]}) begin
                    failures++; $display("FAIL rnd_data_fields dut%0d cyc%0d: got %b/%h/%h/%h want %b/%h/%h/%h", k, cyc,
                        obs_we[k], obs_be[k], obs_addr[k], obs_wdata[k], exp_we[k], exp_be[k], exp_addr[k], exp_wdata[k]);
                end
                checks++; if (obs_rv[k] !== exp_rv[k]) begin failures++; $display("FAIL rnd_rvalid dut%0d cyc%0d: got %b want %b", k, cyc, obs_rv[k], exp_rv[k]); end
                for (int i = 0; i < 2; i++) begin
                    if (exp_rv[k][i]) begin
                        checks++; if (obs_rdata[k][i] !== exp_rdata[k]) begin failures++; $display("FAIL rnd_rdata dut%0d m%0d cyc%0d: got %h want %h", k, i, cyc, obs_rdata[k][i], exp_rdata[k]); end
                    end
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            last_w[k] = 1; owner[k] = -1; beats[k] = 0; pend[k] = 1'b0;
            pend_id[k] = 0; pend_data[k] = 32'h0;
            exp_gnt[k] = 2'b00;
        end
        idle_all();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_fixed_prio();
        test_write_read();
        test_lock();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
